// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the two-master AXI read-address arbiter.
// AXI field widths match the bridge: ID 4, IDS 8, ADDR 32, LEN 4, SIZE 3.
package axi_arb_pkg;

  localparam int ID_W    = 4;
  localparam int IDS_W   = 8;
  localparam int ADDR_W  = 32;
  localparam int LEN_W   = 4;
  localparam int SIZE_W  = 3;
  localparam int BURST_W = 2;

  localparam logic MST_IF   = 1'b0;
  localparam logic MST_DATA = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [ID_W-1:0]    id;
    logic [ADDR_W-1:0]  addr;
    logic [LEN_W-1:0]   len;
    logic [SIZE_W-1:0]  size;
    logic [BURST_W-1:0] burst;
  } ar_t;

  function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
    return (v == {LEN_W{1'b1}}) ? v : v + {{(LEN_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: on a tie the master that was not served last wins.
// Purely combinational; the caller owns last_grant and the grant register.
module rr_arbiter2
  import axi_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       gnt_idx_o,
  output logic       gnt_vld_o
);

  always_comb begin
    gnt_vld_o = |req_i;
    gnt_idx_o = MST_IF;
    if (&req_i) begin
      gnt_idx_o = ~last_grant_i;
    end else if (req_i[MST_DATA]) begin
      gnt_idx_o = MST_DATA;
    end
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares the AR path between instruction and data masters, one burst in flight, R routed by grant.
// AR valid one cycle after request; R path is a zero-cycle pass-through; len_err registered.
module axi_read_arbiter
  import axi_arb_pkg::*;
(
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic [ID_W-1:0]     ARID_M0,
  input  logic [ADDR_W-1:0]   ARADDR_M0,
  input  logic [LEN_W-1:0]    ARLEN_M0,
  input  logic [SIZE_W-1:0]   ARSIZE_M0,
  input  logic [BURST_W-1:0]  ARBURST_M0,
  input  logic                ARVALID_M0,
  output logic                ARREADY_M0,
  input  logic [ID_W-1:0]     ARID_M1,
  input  logic [ADDR_W-1:0]   ARADDR_M1,
  input  logic [LEN_W-1:0]    ARLEN_M1,
  input  logic [SIZE_W-1:0]   ARSIZE_M1,
  input  logic [BURST_W-1:0]  ARBURST_M1,
  input  logic                ARVALID_M1,
  output logic                ARREADY_M1,
  output logic [IDS_W-1:0]    ARID_S,
  output logic [ADDR_W-1:0]   ARADDR_S,
  output logic [LEN_W-1:0]    ARLEN_S,
  output logic [SIZE_W-1:0]   ARSIZE_S,
  output logic [BURST_W-1:0]  ARBURST_S,
  output logic                ARVALID_S,
  input  logic                ARREADY_S,
  input  logic [IDS_W-1:0]    RID_S,
  input  logic                RLAST_S,
  input  logic                RVALID_S,
  output logic                RREADY_S,
  output logic [ID_W-1:0]     RID_M0,
  output logic [ID_W-1:0]     RID_M1,
  output logic                RVALID_M0,
  output logic                RVALID_M1,
  input  logic                RREADY_M0,
  input  logic                RREADY_M1,
  output logic                busy,
  output logic                len_err
);

  arb_state_e        state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [LEN_W-1:0]  exp_len_q, exp_len_d;
  logic              len_err_q, len_err_d;

  ar_t               ar_m0, ar_m1, ar_sel, ar_out;
  logic [IDS_W-1:0]  ar_id_s;
  logic              arv_sel, rrdy_sel, r_hs;
  logic              rr_idx, rr_vld;
  logic              unused_rid_hi;

  assign ar_m0 = {ARID_M0, ARADDR_M0, ARLEN_M0, ARSIZE_M0, ARBURST_M0};
  assign ar_m1 = {ARID_M1, ARADDR_M1, ARLEN_M1, ARSIZE_M1, ARBURST_M1};

  assign ar_sel   = grant_q ? ar_m1 : ar_m0;
  assign arv_sel  = grant_q ? ARVALID_M1 : ARVALID_M0;
  assign rrdy_sel = grant_q ? RREADY_M1 : RREADY_M0;
  assign r_hs     = RVALID_S & rrdy_sel;

  // The returning master index in RID_S[7:4] is not trusted; routing follows grant_q.
  assign unused_rid_hi = ^RID_S[IDS_W-1:ID_W];

  rr_arbiter2 u_rr (
    .req_i        ({ARVALID_M1, ARVALID_M0}),
    .last_grant_i (last_grant_q),
    .gnt_idx_o    (rr_idx),
    .gnt_vld_o    (rr_vld)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    exp_len_d    = exp_len_q;
    len_err_d    = 1'b0;
    ar_out       = '0;
    ar_id_s      = '0;
    ARVALID_S    = 1'b0;
    ARREADY_M0   = 1'b0;
    ARREADY_M1   = 1'b0;
    RVALID_M0    = 1'b0;
    RVALID_M1    = 1'b0;
    RREADY_S     = 1'b0;

    case (state_q)
      IDLE: begin
        if (rr_vld) begin
          grant_d = rr_idx;
          state_d = ADDR;
        end
      end
      ADDR: begin
        ar_out    = ar_sel;
        ar_id_s   = {{(IDS_W-ID_W-1){1'b0}}, grant_q, ar_sel.id};
        ARVALID_S = arv_sel;
        if (grant_q) ARREADY_M1 = ARREADY_S;
        else         ARREADY_M0 = ARREADY_S;
        if (arv_sel && ARREADY_S) begin
          exp_len_d  = ar_sel.len;
          beat_cnt_d = '0;
          state_d    = DATA;
        end
      end
      DATA: begin
        if (grant_q) RVALID_M1 = RVALID_S;
        else         RVALID_M0 = RVALID_S;
        RREADY_S = rrdy_sel;
        if (r_hs) begin
          beat_cnt_d = sat_inc(beat_cnt_q);
          // Flag both a short burst (early RLAST) and an overlong one (missing RLAST).
          len_err_d  = RLAST_S ? (beat_cnt_q != exp_len_q) : (beat_cnt_q == exp_len_q);
          if (RLAST_S) begin
            last_grant_d = grant_q;
            state_d      = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q      <= IDLE;
      grant_q      <= MST_IF;
      last_grant_q <= MST_DATA;
      beat_cnt_q   <= '0;
      exp_len_q    <= '0;
      len_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      exp_len_q    <= exp_len_d;
      len_err_q    <= len_err_d;
    end
  end

  assign ARID_S    = ar_id_s;
  assign ARADDR_S  = ar_out.addr;
  assign ARLEN_S   = ar_out.len;
  assign ARSIZE_S  = ar_out.size;
  assign ARBURST_S = ar_out.burst;

  assign RID_M0  = RID_S[ID_W-1:0];
  assign RID_M1  = RID_S[ID_W-1:0];
  assign busy    = (state_q != IDLE);
  assign len_err = len_err_q;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Cycle-by-cycle vector table for axi_read_arbiter plus burst-length and fairness sequences.
module tb_axi_read_arbiter;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [3:0]  ARID_M0, ARID_M1, ARLEN_M0, ARLEN_M1;
  logic [31:0] ARADDR_M0, ARADDR_M1;
  logic [2:0]  ARSIZE_M0, ARSIZE_M1;
  logic [1:0]  ARBURST_M0, ARBURST_M1;
  logic        ARVALID_M0, ARVALID_M1, ARREADY_M0, ARREADY_M1;
  logic [7:0]  ARID_S;
  logic [31:0] ARADDR_S;
  logic [3:0]  ARLEN_S;
  logic [2:0]  ARSIZE_S;
  logic [1:0]  ARBURST_S;
  logic        ARVALID_S, ARREADY_S;
  logic [7:0]  RID_S;
  logic        RLAST_S, RVALID_S, RREADY_S;
  logic [3:0]  RID_M0, RID_M1;
  logic        RVALID_M0, RVALID_M1, RREADY_M0, RREADY_M1;
  logic        busy, len_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 ACLK = ~ACLK;

  axi_read_arbiter dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .ARID_M0(ARID_M0), .ARADDR_M0(ARADDR_M0), .ARLEN_M0(ARLEN_M0), .ARSIZE_M0(ARSIZE_M0),
    .ARBURST_M0(ARBURST_M0), .ARVALID_M0(ARVALID_M0), .ARREADY_M0(ARREADY_M0),
    .ARID_M1(ARID_M1), .ARADDR_M1(ARADDR_M1), .ARLEN_M1(ARLEN_M1), .ARSIZE_M1(ARSIZE_M1),
    .ARBURST_M1(ARBURST_M1), .ARVALID_M1(ARVALID_M1), .ARREADY_M1(ARREADY_M1),
    .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S), .ARSIZE_S(ARSIZE_S),
    .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
    .RID_S(RID_S), .RLAST_S(RLAST_S), .RVALID_S(RVALID_S), .RREADY_S(RREADY_S),
    .RID_M0(RID_M0), .RID_M1(RID_M1), .RVALID_M0(RVALID_M0), .RVALID_M1(RVALID_M1),
    .RREADY_M0(RREADY_M0), .RREADY_M1(RREADY_M1), .busy(busy), .len_err(len_err)
  );

  typedef struct {
    logic        rst_n, arv0, arv1;
    logic [3:0]  len0, len1;
    logic        ardy, rvld, rlast;
    logic [7:0]  rid;
    logic        rrdy0, rrdy1;
    logic        x_arvld, x_ardy0, x_ardy1;
    logic [7:0]  x_arid;
    logic [31:0] x_addr;
    logic [3:0]  x_len;
    logic        x_rvld0, x_rvld1, x_rrdy;
    logic [3:0]  x_rid;
    logic        x_busy, x_lerr;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t v(
      input logic rst_n, input logic arv0, input logic arv1, input logic [3:0] len0, input logic [3:0] len1,
      input logic ardy, input logic rvld, input logic rlast, input logic [7:0] rid, input logic rrdy0, input logic rrdy1,
      input logic x_arvld, input logic x_ardy0, input logic x_ardy1, input logic [7:0] x_arid, input logic [31:0] x_addr,
      input logic [3:0] x_len, input logic x_rvld0, input logic x_rvld1, input logic x_rrdy, input logic [3:0] x_rid,
      input logic x_busy, input logic x_lerr);
    vec_t r;
    r.rst_n = rst_n; r.arv0 = arv0; r.arv1 = arv1; r.len0 = len0; r.len1 = len1;
    r.ardy = ardy; r.rvld = rvld; r.rlast = rlast; r.rid = rid; r.rrdy0 = rrdy0; r.rrdy1 = rrdy1;
    r.x_arvld = x_arvld; r.x_ardy0 = x_ardy0; r.x_ardy1 = x_ardy1; r.x_arid = x_arid; r.x_addr = x_addr;
    r.x_len = x_len; r.x_rvld0 = x_rvld0; r.x_rvld1 = x_rvld1; r.x_rrdy = x_rrdy; r.x_rid = x_rid;
    r.x_busy = x_busy; r.x_lerr = x_lerr;
    return r;
  endfunction

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Read burst through the handshake interface; reports whether len_err was seen.
  task automatic burst(input string nm, input logic m, input logic [3:0] len, input int nbeats, input logic exp_err);
    logic got = 1'b0;
    logic seen = 1'b0;
    @(posedge ACLK); #1;
    ARREADY_S = 1'b1;
    if (m) begin ARVALID_M1 = 1'b1; ARLEN_M1 = len; RREADY_M1 = 1'b1; end
    else   begin ARVALID_M0 = 1'b1; ARLEN_M0 = len; RREADY_M0 = 1'b1; end
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge ACLK);
      got = m ? ARREADY_M1 : ARREADY_M0;
      if (!got) begin @(posedge ACLK); #1; end
    end
    check({nm, "_ar"}, {63'd0, got}, 64'd1);
    @(posedge ACLK); #1;
    ARVALID_M0 = 1'b0; ARVALID_M1 = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      RVALID_S = 1'b1;
      RLAST_S  = (b == nbeats - 1);
      @(negedge ACLK);
      seen |= len_err;
      @(posedge ACLK); #1;
    end
    RVALID_S = 1'b0; RLAST_S = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge ACLK);
      seen |= len_err;
      @(posedge ACLK); #1;
    end
    check({nm, "_len_err"}, {63'd0, seen}, {63'd0, exp_err});
    check({nm, "_idle"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bstart, bend, hs;
    int ng;
    logic [3:0] exp_g;
    logic [64:0] act, exp;
    logic [4:0]  xsb;

    ARESETn = 1'b0;
    ARID_M0 = 4'h5; ARADDR_M0 = 32'h0000_0040; ARSIZE_M0 = 3'd2; ARBURST_M0 = 2'd1;
    ARID_M1 = 4'hA; ARADDR_M1 = 32'h0000_1000; ARSIZE_M1 = 3'd3; ARBURST_M1 = 2'd2;
    ARLEN_M0 = '0; ARLEN_M1 = '0; ARVALID_M0 = 1'b0; ARVALID_M1 = 1'b0; ARREADY_S = 1'b0;
    RID_S = '0; RLAST_S = 1'b0; RVALID_S = 1'b0; RREADY_M0 = 1'b0; RREADY_M1 = 1'b0;

    // reset state with active inputs
    tv.push_back(v(0,1,1,0,0,1,1,0,8'h00,1,1, 0,0,0,8'h00,32'h0,0, 0,0,0,4'h0, 0,0));
    // tie from reset: M0, M1, M0, M1
    tv.push_back(v(1,1,1,0,0,1,1,0,8'h00,1,0, 0,0,0,8'h00,32'h0,0, 0,0,0,4'h0, 0,0));
    tv.push_back(v(1,1,1,0,0,1,0,0,8'h00,0,0, 1,1,0,8'h05,32'h40,0, 0,0,0,4'h0, 1,0));
    tv.push_back(v(1,1,1,0,0,1,1,1,8'h13,1,0, 0,0,0,8'h00,32'h0,0, 1,0,1,4'h3, 1,0));
    tv.push_back(v(1,1,1,0,0,1,0,0,8'h00,0,0, 0,0,0,8'h00,32'h0,0, 0,0,0,4'h0, 0,0));
    tv.push_back(v(1,1,1,0,0,1,0,0,8'h00,0,0, 1,0,1,8'h1A,32'h1000,0, 0,0,0,4'h0, 1,0));
    tv.push_back(v(1,1,1,0,0,1,1,1,8'h07,0,1, 0,0,0,8'h00,32'h0,0, 0,1,1,4'h7, 1,0));
    tv.push_back(v(1,1,1,0,0,1,0,0,8'h00,0,0, 0,0,0,8'h00,32'h0,0, 0,0,0,4'h0, 0,0));
    tv.push_back(v(1,1,1,0,0,1,0,0,8'h00,0,0, 1,1,0,8'h05,32'h40,0, 0,0,0,4'h0, 1,0));
    tv.push_back(v(1,1,1,0,0,1,1,1,8'h00,1,1, 0,0,0,8'h00,32'h0,0, 1,0,1,4'h0, 1,0));
    tv.push_back(v(1,1,1,0,0,1,0,0,8'h00,0,0, 0,0,0,8'h00,32'h0,0, 0,0,0,4'h0, 0,0));
    tv.push_back(v(1,1,1,0,0,1,0,0,8'h00,0,0, 1,0,1,8'h1A,32'h1000,0, 0,0,0,4'h0, 1,0));
    tv.push_back(v(1,1,1,0,0,1,1,1,8'h00,1,0, 0,0,0,8'h00,32'h0,0, 0,1,0,4'h0, 1,0));
    tv.push_back(v(1,0,0,0,0,1,1,1,8'h00,0,1, 0,0,0,8'h00,32'h0,0, 0,1,1,4'h0, 1,0));
    tv.push_back(v(1,0,0,0,0,0,0,0,8'h00,0,0, 0,0,0,8'h00,32'h0,0, 0,0,0,4'h0, 0,0));
    // single M0 read, ARLEN 0
    tv.push_back(v(1,1,0,0,0,0,0,0,8'h00,0,0, 0,0,0,8'h00,32'h0,0, 0,0,0,4'h0, 0,0));
    tv.push_back(v(1,1,0,0,0,1,0,0,8'h00,0,0, 1,1,0,8'h05,32'h40,0, 0,0,0,4'h0, 1,0));
    tv.push_back(v(1,0,0,0,0,0,1,1,8'h00,1,1, 0,0,0,8'h00,32'h0,0, 1,0,1,4'h0, 1,0));
    tv.push_back(v(1,0,0,0,0,0,0,0,8'h00,0,0, 0,0,0,8'h00,32'h0,0, 0,0,0,4'h0, 0,0));
    // M1 burst ARLEN 3, RREADY_M1 stalls beats 2 and 3
    bstart = tv.size();
    tv.push_back(v(1,0,1,0,3,0,0,0,8'h00,0,0, 0,0,0,8'h00,32'h0,0, 0,0,0,4'h0, 0,0));
    tv.push_back(v(1,0,1,0,3,1,0,0,8'h00,0,0, 1,0,1,8'h1A,32'h1000,3, 0,0,0,4'h0, 1,0));
    tv.push_back(v(1,0,0,0,3,0,1,0,8'h00,0,1, 0,0,0,8'h00,32'h0,0, 0,1,1,4'h0, 1,0));
    tv.push_back(v(1,0,0,0,3,0,1,0,8'h00,1,0, 0,0,0,8'h00,32'h0,0, 0,1,0,4'h0, 1,0));
    tv.push_back(v(1,0,0,0,3,0,1,0,8'h00,1,0, 0,0,0,8'h00,32'h0,0, 0,1,0,4'h0, 1,0));
    tv.push_back(v(1,0,0,0,3,0,1,0,8'h00,0,1, 0,0,0,8'h00,32'h0,0, 0,1,1,4'h0, 1,0));
    tv.push_back(v(1,0,0,0,3,0,1,0,8'h00,1,0, 0,0,0,8'h00,32'h0,0, 0,1,0,4'h0, 1,0));
    tv.push_back(v(1,0,0,0,3,0,1,0,8'h00,0,1, 0,0,0,8'h00,32'h0,0, 0,1,1,4'h0, 1,0));
    tv.push_back(v(1,0,0,0,3,0,1,1,8'h00,0,1, 0,0,0,8'h00,32'h0,0, 0,1,1,4'h0, 1,0));
    tv.push_back(v(1,0,0,0,3,0,0,0,8'h00,0,0, 0,0,0,8'h00,32'h0,0, 0,0,0,4'h0, 0,0));
    bend = tv.size() - 1;
    // early RLAST on beat 2 of ARLEN 3
    tv.push_back(v(1,1,0,3,0,0,0,0,8'h00,0,0, 0,0,0,8'h00,32'h0,0, 0,0,0,4'h0, 0,0));
    tv.push_back(v(1,1,0,3,0,1,0,0,8'h00,0,0, 1,1,0,8'h05,32'h40,3, 0,0,0,4'h0, 1,0));
    tv.push_back(v(1,0,0,3,0,0,1,0,8'h00,1,0, 0,0,0,8'h00,32'h0,0, 1,0,1,4'h0, 1,0));
    tv.push_back(v(1,0,0,3,0,0,1,1,8'h00,1,0, 0,0,0,8'h00,32'h0,0, 1,0,1,4'h0, 1,0));
    tv.push_back(v(1,0,0,3,0,0,0,0,8'h00,0,0, 0,0,0,8'h00,32'h0,0, 0,0,0,4'h0, 0,1));
    tv.push_back(v(1,0,0,3,0,0,0,0,8'h00,0,0, 0,0,0,8'h00,32'h0,0, 0,0,0,4'h0, 0,0));
    // non-last beat where count equals ARLEN 0, then the late RLAST
    tv.push_back(v(1,1,0,0,0,0,0,0,8'h00,0,0, 0,0,0,8'h00,32'h0,0, 0,0,0,4'h0, 0,0));
    tv.push_back(v(1,1,0,0,0,1,0,0,8'h00,0,0, 1,1,0,8'h05,32'h40,0, 0,0,0,4'h0, 1,0));
    tv.push_back(v(1,0,0,0,0,0,1,0,8'h00,1,0, 0,0,0,8'h00,32'h0,0, 1,0,1,4'h0, 1,0));
    tv.push_back(v(1,0,0,0,0,0,1,1,8'h00,1,0, 0,0,0,8'h00,32'h0,0, 1,0,1,4'h0, 1,1));
    tv.push_back(v(1,0,0,0,0,0,0,0,8'h00,0,0, 0,0,0,8'h00,32'h0,0, 0,0,0,4'h0, 0,1));
    tv.push_back(v(1,0,0,0,0,0,0,0,8'h00,0,0, 0,0,0,8'h00,32'h0,0, 0,0,0,4'h0, 0,0));
    // ARREADY_S low for 5 cycles
    tv.push_back(v(1,1,0,2,0,0,0,0,8'h00,0,0, 0,0,0,8'h00,32'h0,0, 0,0,0,4'h0, 0,0));
    for (int i = 0; i < 5; i++)
      tv.push_back(v(1,1,0,2,0,0,0,0,8'h00,0,0, 1,0,0,8'h05,32'h40,2, 0,0,0,4'h0, 1,0));
    tv.push_back(v(1,1,0,2,0,1,0,0,8'h00,0,0, 1,1,0,8'h05,32'h40,2, 0,0,0,4'h0, 1,0));
    tv.push_back(v(1,0,0,2,0,0,1,0,8'h00,1,0, 0,0,0,8'h00,32'h0,0, 1,0,1,4'h0, 1,0));
    tv.push_back(v(1,0,0,2,0,0,1,0,8'h00,1,0, 0,0,0,8'h00,32'h0,0, 1,0,1,4'h0, 1,0));
    tv.push_back(v(1,0,0,2,0,0,1,1,8'h00,1,0, 0,0,0,8'h00,32'h0,0, 1,0,1,4'h0, 1,0));
    tv.push_back(v(1,0,0,2,0,0,0,0,8'h00,0,0, 0,0,0,8'h00,32'h0,0, 0,0,0,4'h0, 0,0));
    // granted master drops ARVALID while in ADDR
    tv.push_back(v(1,1,0,0,0,0,0,0,8'h00,0,0, 0,0,0,8'h00,32'h0,0, 0,0,0,4'h0, 0,0));
    tv.push_back(v(1,0,0,0,0,0,0,0,8'h00,0,0, 0,0,0,8'h05,32'h40,0, 0,0,0,4'h0, 1,0));
    tv.push_back(v(1,1,0,0,0,1,0,0,8'h00,0,0, 1,1,0,8'h05,32'h40,0, 0,0,0,4'h0, 1,0));
    tv.push_back(v(1,0,0,0,0,0,1,1,8'h00,1,0, 0,0,0,8'h00,32'h0,0, 1,0,1,4'h0, 1,0));
    tv.push_back(v(1,0,0,0,0,0,0,0,8'h00,0,0, 0,0,0,8'h00,32'h0,0, 0,0,0,4'h0, 0,0));
    // reset mid-DATA of ARLEN 3, then M1-only request
    tv.push_back(v(1,1,0,3,0,0,0,0,8'h00,0,0, 0,0,0,8'h00,32'h0,0, 0,0,0,4'h0, 0,0));
    tv.push_back(v(1,1,0,3,0,1,0,0,8'h00,0,0, 1,1,0,8'h05,32'h40,3, 0,0,0,4'h0, 1,0));
    tv.push_back(v(1,0,0,3,0,0,1,0,8'h00,1,0, 0,0,0,8'h00,32'h0,0, 1,0,1,4'h0, 1,0));
    tv.push_back(v(0,0,1,3,0,1,1,0,8'h00,1,1, 0,0,0,8'h00,32'h0,0, 0,0,0,4'h0, 0,0));
    tv.push_back(v(1,0,1,0,0,0,0,0,8'h00,0,0, 0,0,0,8'h00,32'h0,0, 0,0,0,4'h0, 0,0));
    tv.push_back(v(1,0,1,0,0,1,0,0,8'h00,0,0, 1,0,1,8'h1A,32'h1000,0, 0,0,0,4'h0, 1,0));
    tv.push_back(v(1,0,0,0,0,0,1,1,8'h00,0,1, 0,0,0,8'h00,32'h0,0, 0,1,1,4'h0, 1,0));
    tv.push_back(v(1,0,0,0,0,0,0,0,8'h00,0,0, 0,0,0,8'h00,32'h0,0, 0,0,0,4'h0, 0,0));

    repeat (2) @(posedge ACLK);
    hs = 0;
    foreach (tv[i]) begin
      @(posedge ACLK); #1;
      ARESETn = tv[i].rst_n; ARVALID_M0 = tv[i].arv0; ARVALID_M1 = tv[i].arv1;
      ARLEN_M0 = tv[i].len0; ARLEN_M1 = tv[i].len1; ARREADY_S = tv[i].ardy;
      RVALID_S = tv[i].rvld; RLAST_S = tv[i].rlast; RID_S = tv[i].rid;
      RREADY_M0 = tv[i].rrdy0; RREADY_M1 = tv[i].rrdy1;
      @(negedge ACLK);
      if (i >= bstart && i <= bend && RVALID_S && RREADY_S) hs++;
      xsb = (tv[i].x_arid == 8'h05) ? {3'd2, 2'd1} : (tv[i].x_arid == 8'h1A) ? {3'd3, 2'd2} : 5'd0;
      act = {ARVALID_S, ARREADY_M0, ARREADY_M1, ARID_S, ARADDR_S, ARLEN_S, RVALID_M0, RVALID_M1, RREADY_S,
             RID_M0, RID_M1, busy, len_err, ARSIZE_S, ARBURST_S};
      exp = {tv[i].x_arvld, tv[i].x_ardy0, tv[i].x_ardy1, tv[i].x_arid, tv[i].x_addr, tv[i].x_len,
             tv[i].x_rvld0, tv[i].x_rvld1, tv[i].x_rrdy, tv[i].x_rid, tv[i].x_rid, tv[i].x_busy, tv[i].x_lerr, xsb};
      n_cmp++;
      if (act !== exp) begin
        n_bad++;
        $display("FAIL vec%0d: got %h expected %h", i, act, exp);
      end
    end
    check("burst_handshakes", 64'(hs), 64'd4);

    burst("len15_16beats", 1'b0, 4'd15, 16, 1'b0);
    burst("len15_15beats", 1'b1, 4'd15, 15, 1'b1);
    burst("len15_17beats", 1'b0, 4'd15, 17, 1'b1);

    // both masters requesting continuously; M0 was served last
    @(posedge ACLK); #1;
    ARVALID_M0 = 1'b1; ARVALID_M1 = 1'b1; ARLEN_M0 = '0; ARLEN_M1 = '0;
    ARREADY_S = 1'b1; RREADY_M0 = 1'b1; RREADY_M1 = 1'b1; RLAST_S = 1'b1;
    ng = 0;
    for (int c = 0; c < 300 && ng < 6; c++) begin
      RVALID_S = ($urandom_range(0, 2) != 0);
      @(negedge ACLK);
      if (ARVALID_S && ARREADY_S) begin
        exp_g = (ng % 2 == 0) ? 4'h1 : 4'h0;
        check("fair_grant", {60'd0, ARID_S[7:4]}, {60'd0, exp_g});
        ng++;
      end
      @(posedge ACLK); #1;
    end
    if (ng < 6) begin
      n_cmp++; n_bad++;
      $display("FAIL fair_timeout: got %0d grants expected 6", ng);
    end
    ARVALID_M0 = 1'b0; ARVALID_M1 = 1'b0; RVALID_S = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axi_read_arbiter.md
# axi_read_arbiter

Read-address arbiter and read-response router for the two-master AXI bridge. It shares the single AR path into the address decoder between master 0 (instruction fetch) and master 1 (data) using round-robin arbitration. It allows one outstanding burst at a time, steers R-channel handshakes back to the owning master, and checks burst length against ARLEN.

## Interface
- AXI widths come from `AXI_define.svh`: ID 4, IDS 8, ADDR 32, LEN 4, SIZE 3. No module parameters.
- Clocking: one clock; reset is asynchronous and active-low.
- ACLK  in  1  clock
- ARESETn  in  1  asynchronous active-low reset
- ARID_M0 / ARID_M1  in  4  master AR IDs
- ARADDR_M0 / ARADDR_M1  in  32  addresses
- ARLEN_M0 / ARLEN_M1  in  4  burst length minus 1
- ARSIZE_M0 / ARSIZE_M1  in  3  sizes
- ARBURST_M0 / ARBURST_M1  in  2  burst types
- ARVALID_M0 / ARVALID_M1  in  1  AR valid
- ARREADY_M0 / ARREADY_M1  out  1  AR ready
- ARID_S  out  8  {master index[3:0], ARID[3:0]}
- ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S  out  32/4/3/2  muxed AR fields to the decoder
- ARVALID_S  out  1  AR valid to the decoder
- ARREADY_S  in  1  decoder READY
- RID_S  in  8  returning read ID
- RLAST_S  in  1  last beat of the burst
- RVALID_S  in  1  read data valid
- RREADY_S  out  1  read data ready to the slave side
- RID_M0 / RID_M1  out  4  RID_S[3:0]
- RVALID_M0 / RVALID_M1  out  1  routed read valid
- RREADY_M0 / RREADY_M1  in  1  master read ready
- busy  out  1  a read transaction is in flight
- len_err  out  1  one-cycle pulse on a burst-length mismatch
- RDATA and RRESP are broadcast to both masters outside this block.

## Operation
- FSM states: IDLE, ADDR, DATA.
- IDLE
  - Any ARVALID_Mx: latch the winner into `grant`, then go to ADDR.
  - Both valid: the master not equal to `last_grant` wins. `last_grant` resets to 1, so M0 wins the first tie.
- ADDR
  - ARVALID_S = ARVALID of the granted master; AR fields are muxed from the granted master.
  - ARREADY_M[grant] = ARREADY_S; the other master's ARREADY = 0.
  - On the handshake: latch ARLEN into `exp_len`, clear `beat_cnt`, go to DATA.
  - If the granted master drops ARVALID (protocol violation), ARVALID_S drops and the FSM stays in ADDR.
- DATA
  - RVALID_M[grant] = RVALID_S; the other master's RVALID = 0.
  - RREADY_S = RREADY_M[grant].
  - RID_S[7:4] differing from `grant` is ignored; routing uses `grant` only.
  - Each R handshake increments `beat_cnt` (4-bit, saturating at 15).
  - Handshake with RLAST_S: `last_grant` <= `grant`, go to IDLE.
  - len_err pulses for one cycle if RLAST arrives with `beat_cnt` != `exp_len`, or if a non-last beat arrives with `beat_cnt` == `exp_len`.
- busy = (state != IDLE).
- ARREADY_Mx is 0 outside ADDR. RVALID_Mx and RREADY_S are 0 outside DATA.

## Timing
- Reset values:
  - state IDLE, `grant` 0, `last_grant` 1, `beat_cnt` 0, `exp_len` 0.
  - All ARREADY_Mx, ARVALID_S, RVALID_Mx, RREADY_S, busy and len_err are 0.
  - AR mux outputs are 0.
- AR latency: ARVALID_Mx rises in cycle 0 (state IDLE), ARVALID_S is asserted in cycle 1. The earliest AR handshake is cycle 1.
- R path is combinational, zero-cycle pass-through.
- Back-to-back: an RLAST handshake in cycle n gives IDLE in n+1 and ARVALID_S for the next master in n+2.
- Fairness: with both masters continuously requesting, grants strictly alternate.
- Reset asserted mid-burst: all state clears immediately and asynchronously. The pending burst is abandoned.
- len_err is registered and asserted in the cycle after the offending handshake.

## Structure
- Package `axi_arb_pkg` holds:
  - enum `arb_state_e` {IDLE, ADDR, DATA}
  - localparams `MST_IF` = 1'b0 and `MST_DATA` = 1'b1
- Sub-module `rr_arbiter2`: inputs req[1:0] and last_grant; outputs a grant index and a valid. Purely combinational; the top level owns the registers.

## Test plan
- Reset: ARESETn low mid-DATA with ARLEN=3 → next cycle all outputs are 0, busy=0; after release an M1-only request is granted.
- Single M0 read: ARADDR_M0=0x0000_0040, ARLEN=0, ARID=5 → ARID_S=0x05 in cycle 1; one beat routed to M0 only; busy falls after RLAST.
- Tie: both ARVALID high from reset → M0 served first, then M1 (ARID_S=0x1x); repeat → M0, M1 alternation.
- Burst ARLEN=3 from M1 with RREADY_M1 stalling beats 2 and 3 → RREADY_S follows RREADY_M1; exactly 4 handshakes; len_err=0.
- Early RLAST on beat 2 of ARLEN=3 → len_err pulses one cycle; FSM returns to IDLE.
- ARREADY_S held low for 5 cycles → ARVALID_S and the AR fields stay stable; ARREADY_M0 stays 0 until ARREADY_S rises.
